hdlc_tx_scheduler: RTL
======================

# hdlc_tx_scheduler

Round-robin transmit scheduler that shares the single HDLC transmitter between two byte-stream requesters. It accepts one frame at a time from the granted requester and loads it into the HDLC Tx buffer through the core's register bus. It then enables transmission, polls for completion and reports the result. It sits between the host-side requesters and the HDLC core's Address/WriteEnable/ReadEnable/DataIn/DataOut port.

## Interface
- MAX_LEN, 126: maximum payload bytes per frame (Tx buffer capacity).
- POLL_HOLDOFF, 4: cycles between the enable write and the first status poll.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous, active-low reset.
- Req_Valid  in  2  per-requester byte valid.
- Req_Data  in  16  requester n byte on [8n+7:8n].
- Req_Last  in  2  final byte of frame.
- Req_Ready  out  2  per-requester byte accept; at most one bit set.
- Abort  in  1  one-cycle abort request for the current frame.
- Busy  out  1  high whenever state is not IDLE.
- Grant_Id  out  1  index of the requester being served.
- Done  out  1  one-cycle pulse: frame transmitted.
- Aborted  out  1  one-cycle pulse: frame aborted.
- Overlength  out  1  one-cycle pulse: bytes beyond MAX_LEN dropped.
- Address  out  3  core register address (0 = Tx_SC, 1 = Tx_Buff).
- WriteEnable  out  1  core register write strobe.
- ReadEnable  out  1  core register read strobe.
- DataIn  out  8  write data to core.
- DataOut  in  8  read data from core; valid the cycle after ReadEnable.

## Operation
- States: IDLE, LOAD, START, HOLD, POLL_RD, POLL_CHK, ABORT, DRAIN.
- IDLE: if any Req_Valid is set, grant by round-robin pointer. The pointer's requester wins on a tie; otherwise the single valid requester wins. Latch Grant_Id and go to LOAD.
- LOAD: Req_Ready[Grant_Id] = 1. Each accepted byte increments the 7-bit count and is written to Address 1.
  - Once count reaches MAX_LEN, further bytes are accepted and dropped until Last, and Overlength pulses once.
  - Accepting Last moves to START.
- START: write 0x02 to Address 0 (Tx_Enable), then HOLD for POLL_HOLDOFF cycles.
- POLL_RD: ReadEnable with Address 0. POLL_CHK: sample DataOut.
  - Bit0 (Tx_Done) = 1: pulse Done and go to IDLE.
  - Otherwise return to POLL_RD.
- Abort: honoured in LOAD, START, HOLD, POLL_RD and POLL_CHK; ignored in IDLE, ABORT and DRAIN. On Abort, go to ABORT and write 0x04 to Address 0 (Tx_AbortFrame).
  - If Last is not yet accepted, continue to DRAIN: Req_Ready stays high and bytes are discarded through Last, then IDLE.
  - Otherwise go straight to IDLE. Aborted pulses on the IDLE entry.
- The round-robin pointer toggles to the other requester on every return to IDLE, whether the frame completed or was aborted.
- Write and read strobes are never asserted in the same cycle.

## Timing
- Reset values: all outputs 0, Address 0, state IDLE, pointer 0, count 0.
- Reset asserted mid-frame returns to IDLE immediately. No partial write completes, and no Done, Aborted or Overlength pulse is issued.
- Grant: Req_Valid seen in IDLE at cycle n gives Req_Ready high at n+1.
- Load: a byte accepted at cycle n is written to the core at n+1 (WriteEnable, Address 1, DataIn = byte). Throughput is one byte per cycle.
- Enable: the enable write occurs the cycle after the last byte's write.
- Polling: the first poll is issued POLL_HOLDOFF cycles after the enable write, with a 2-cycle poll period.
- Done: pulses the cycle after the POLL_CHK that sees Tx_Done.
- Abort: Abort at cycle n (LOAD) drops no byte already accepted. The abort write occurs at n+1, with Req_Ready kept high for draining.
- Simultaneous Abort and Last accept: the byte is accepted and Abort wins; DRAIN is skipped.

## Configuration
- HDLC_TXSCHED_ABORT_EN defined: the Abort input, the ABORT/DRAIN states and the Aborted pulse are as above.
- HDLC_TXSCHED_ABORT_EN undefined: Abort is ignored, Aborted is tied 0, and the ABORT/DRAIN states are not built.

## Test plan
- Requester 0 sends 3 bytes 0xA1, 0xA2, 0xA3 (Last on 0xA3), and the core returns DataOut = 0x01 on the second poll.
  - Required: Tx_Buff writes 0xA1, 0xA2, 0xA3; Tx_SC write 0x02; exactly two reads; Done pulses with Grant_Id = 0.
- Both requesters hold valid frames continuously.
  - Required: grants alternate 0, 1, 0, 1 over four frames.
- Requester 1 sends 130 bytes.
  - Required: exactly 126 Tx_Buff writes; Overlength pulses once; all 130 bytes are handshaked.
- Abort while requester 0 is loading byte 5 of 10.
  - Required: Tx_SC write 0x04; bytes 6–10 are drained without writes; Aborted pulses; the next grant goes to requester 1.
- Rst driven low during POLL.
  - Required: outputs 0 asynchronously; no Done pulse; after release, a new frame from requester 0 completes normally.
- With HDLC_TXSCHED_ABORT_EN undefined, pulse Abort during LOAD.
  - Required: the frame completes with Done; no 0x04 write occurs.

Source files
------------

// File: rtl/hdlc_tx_scheduler.sv
// hdlc_tx_scheduler: round-robin scheduler sharing one HDLC transmitter between
// two byte-stream requesters. Each frame goes into the core Tx buffer over the
// register bus. The scheduler then enables transmission and polls Tx_SC for Tx_Done.
// Optional feature macro: HDLC_TXSCHED_ABORT_EN (Abort input, ABORT/DRAIN states,
// Aborted pulse). Without it Abort is ignored and Aborted is tied low.
module hdlc_tx_scheduler #(
  parameter int unsigned MAX_LEN      = 126,
  parameter int unsigned POLL_HOLDOFF = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Req_Valid,
  input  logic [15:0] Req_Data,
  input  logic [1:0]  Req_Last,
  output logic [1:0]  Req_Ready,
  input  logic        Abort,
  output logic        Busy,
  output logic        Grant_Id,
  output logic        Done,
  output logic        Aborted,
  output logic        Overlength,
  output logic [2:0]  Address,
  output logic        WriteEnable,
  output logic        ReadEnable,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut
);

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned HOLD_W = (POLL_HOLDOFF > 1) ? $clog2(POLL_HOLDOFF) : 1;

  localparam logic [2:0] ADDR_TX_SC   = 3'd0;
  localparam logic [2:0] ADDR_TX_BUFF = 3'd1;
  localparam logic [7:0] TX_ENABLE    = 8'h02;
`ifdef HDLC_TXSCHED_ABORT_EN
  localparam logic [7:0] TX_ABORT     = 8'h04;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    START    = 3'd2,
    HOLD     = 3'd3,
    POLL_RD  = 3'd4,
    POLL_CHK = 3'd5
`ifdef HDLC_TXSCHED_ABORT_EN
    ,
    ABORT    = 3'd6,
    DRAIN    = 3'd7
`endif
  } state_t;

  state_t              r_state;
  logic                r_ptr;
  logic                r_grant;
  logic [1:0]          r_req_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_ovl;
  logic                r_ovl_seen;
  logic [2:0]          r_addr;
  logic                r_we;
  logic                r_re;
  logic [7:0]          r_din;
  logic [CNT_W-1:0]    r_count;
  logic [HOLD_W-1:0]   r_hold;

  logic                w_rr_pick;
  logic                w_accept;
  logic                w_sel_last;
  logic [7:0]          w_sel_data;

  // Requester selection and handshake decode
  assign w_rr_pick  = Req_Valid[r_ptr] ? r_ptr : ~r_ptr;
  assign w_accept   = |(r_req_ready & Req_Valid);
  assign w_sel_last = r_grant ? Req_Last[1] : Req_Last[0];
  assign w_sel_data = r_grant ? Req_Data[15:8] : Req_Data[7:0];

`ifdef HDLC_TXSCHED_ABORT_EN
  logic r_aborted;
  logic r_drain;
  logic w_abort;
  logic w_unused;

  // Abort is only honoured while a frame is being loaded or transmitted
  assign w_abort  = Abort && (r_state inside {LOAD, START, HOLD, POLL_RD, POLL_CHK});
  assign w_unused = ^DataOut[7:1];
  assign Aborted  = r_aborted;
`else
  logic w_unused;

  assign w_unused = ^{DataOut[7:1], Abort};
  assign Aborted  = 1'b0;
`endif

  assign Req_Ready   = r_req_ready;
  assign Busy        = r_busy;
  assign Grant_Id    = r_grant;
  assign Done        = r_done;
  assign Overlength  = r_ovl;
  assign Address     = r_addr;
  assign WriteEnable = r_we;
  assign ReadEnable  = r_re;
  assign DataIn      = r_din;

  // Scheduler FSM with registered bus strobes and status pulses
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_grant     <= 1'b0;
      r_req_ready <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovl       <= 1'b0;
      r_ovl_seen  <= 1'b0;
      r_addr      <= 3'd0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_din       <= 8'h00;
      r_count     <= '0;
      r_hold      <= '0;
`ifdef HDLC_TXSCHED_ABORT_EN
      r_aborted   <= 1'b0;
      r_drain     <= 1'b0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_done <= 1'b0;
      r_ovl  <= 1'b0;
`ifdef HDLC_TXSCHED_ABORT_EN
      r_aborted <= 1'b0;
      if (w_abort) begin
        // A byte accepted alongside Abort is consumed but never written
        r_state <= ABORT;
        r_we    <= 1'b1;
        r_addr  <= ADDR_TX_SC;
        r_din   <= TX_ABORT;
        if ((r_state == LOAD) && !(w_accept && w_sel_last)) begin
          r_drain <= 1'b1;
        end else begin
          r_drain     <= 1'b0;
          r_req_ready <= 2'b00;
        end
      end else
`endif
      begin
        case (r_state)
          IDLE: begin
            if (|Req_Valid) begin
              r_grant     <= w_rr_pick;
              r_req_ready <= w_rr_pick ? 2'b10 : 2'b01;
              r_busy      <= 1'b1;
              r_count     <= '0;
              r_ovl_seen  <= 1'b0;
              r_state     <= LOAD;
            end
          end
          LOAD: begin
            if (w_accept) begin
              if (r_count < CNT_W'(MAX_LEN)) begin
                r_we    <= 1'b1;
                r_addr  <= ADDR_TX_BUFF;
                r_din   <= w_sel_data;
                r_count <= r_count + CNT_W'(1);
              end else if (!r_ovl_seen) begin
                r_ovl      <= 1'b1;
                r_ovl_seen <= 1'b1;
              end
              if (w_sel_last) begin
                r_req_ready <= 2'b00;
                r_state     <= START;
              end
            end
          end
          START: begin
            r_we    <= 1'b1;
            r_addr  <= ADDR_TX_SC;
            r_din   <= TX_ENABLE;
            r_hold  <= '0;
            r_state <= HOLD;
          end
          HOLD: begin
            if (r_hold == HOLD_W'(POLL_HOLDOFF - 1)) begin
              r_re    <= 1'b1;
              r_addr  <= ADDR_TX_SC;
              r_state <= POLL_RD;
            end else begin
              r_hold <= r_hold + HOLD_W'(1);
            end
          end
          POLL_RD: begin
            r_state <= POLL_CHK;
          end
          POLL_CHK: begin
            if (DataOut[0]) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_ptr   <= ~r_ptr;
              r_state <= IDLE;
            end else begin
              r_re    <= 1'b1;
              r_addr  <= ADDR_TX_SC;
              r_state <= POLL_RD;
            end
          end
`ifdef HDLC_TXSCHED_ABORT_EN
          ABORT: begin
            if (r_drain && !(w_accept && w_sel_last)) begin
              r_state <= DRAIN;
            end else begin
              r_aborted   <= 1'b1;
              r_req_ready <= 2'b00;
              r_busy      <= 1'b0;
              r_ptr       <= ~r_ptr;
              r_drain     <= 1'b0;
              r_state     <= IDLE;
            end
          end
          DRAIN: begin
            if (w_accept && w_sel_last) begin
              r_aborted   <= 1'b1;
              r_req_ready <= 2'b00;
              r_busy      <= 1'b0;
              r_ptr       <= ~r_ptr;
              r_drain     <= 1'b0;
              r_state     <= IDLE;
            end
          end
`endif
          default: begin
            r_req_ready <= 2'b00;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
